spi_ram: RTL and testbench
==========================

# spi_ram

Single-port byte RAM that consumes the 10-bit command words produced by the SPI slave and returns read data to it for serialisation on MISO. It sits directly downstream of the slave on the `rx_data`/`rx_valid` path and upstream of it on the `tx_data`/`tx_valid` path. Commands set the write address, write a byte, set the read address, or read a byte back.

## Interface
- `MEM_DEPTH`, 256, number of 8-bit words; must equal 2**`ADDR_SIZE`
- `ADDR_SIZE`, 8, address width; 1..8

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `din`  in  10  command word from slave (`rx_data`); [9:8] opcode, [7:0] payload
- `rx_valid`  in  1  command-valid from slave
- `dout`  out  8  read data to slave (`tx_data`)
- `tx_valid`  out  1  one-cycle pulse, `dout` valid
- `err`  out  1  sticky protocol-error flag

## Operation
- Command accepted only on the `rx_valid` rising edge: `rx_valid`=1 this cycle and 0 the previous cycle (registered `rx_valid_d`). Level held high for multiple cycles counts as one command.
- Opcode decode, payload `p` = `din[ADDR_SIZE-1:0]`:
  - 00 WR_ADDR: `wr_addr` <= p; `wr_addr_ok` <= 1.
  - 01 WR_DATA: if `wr_addr_ok`, mem[`wr_addr`] <= `din[7:0]`; else no write, `err` <= 1.
  - 10 RD_ADDR: `rd_addr` <= p; `rd_addr_ok` <= 1.
  - 11 RD_DATA: if `rd_addr_ok`, `dout` <= mem[`rd_addr`], `tx_valid` <= 1; else `err` <= 1, no pulse.
- `tx_valid` forced to 0 on every cycle not launching a read; it is never high two consecutive cycles.
- `dout` holds its last value between reads.
- Address flags and addresses persist across commands; repeated RD_DATA re-reads the same address.
- `err` sets and stays set until reset; does not block further commands.
- Reset mid-command: command is dropped, nothing written.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `err`=0, `wr_addr`=0, `rd_addr`=0, `wr_addr_ok`=0, `rd_addr_ok`=0, `rx_valid_d`=0. Memory contents not reset; retained through reset.
- Write latency: mem updated at the edge sampling the `rx_valid` rise; a read of that address in the following command returns the new byte.
- Read latency: edge E samples the RD_DATA rise; `tx_valid`=1 and `dout` valid for exactly the cycle after E; `tx_valid`=0 after E+1. This matches the slave capturing `tx_data` two cycles after it raises `rx_valid`. The slave then starts shifting only when `tx_valid` is low.
- One memory access per cycle; no read/write collision possible.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - after each accepted WR_DATA, `wr_addr` <= `wr_addr`+1.
  - after each successful RD_DATA, `rd_addr` <= `rd_addr`+1.
  - both wrap MEM_DEPTH-1 -> 0.
- Not defined: addresses change only via WR_ADDR/RD_ADDR.

## Structure
- Package `spi_ram_pkg`: opcode constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11; default `MEM_DEPTH`/`ADDR_SIZE`.
- Sub-module `spi_ram_array`:
  - storage only, one synchronous write port and one registered read port, no reset.
  - top holds decode, edge detect, address/flag registers, `tx_valid`, `err`.

## Test plan
- Reset, then WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> `tx_valid` one-cycle pulse one cycle after the rise, `dout`=0xA5, `err`=0.
- `rx_valid` held high 5 cycles with WR_DATA 0x11 (autoinc build) -> single write; `wr_addr` advances by exactly 1.
- RD_DATA before any RD_ADDR after reset -> no `tx_valid`, `err`=1; a later valid read still works with `err` still 1.
- Autoinc build: WR_ADDR 0xFF, WR_DATA 0x01, WR_DATA 0x02 -> mem[0xFF]=0x01, mem[0x00]=0x02.
- Non-autoinc build: two RD_DATA at address 0x10 -> both return the same byte.
- Assert `rst_n` low mid-session after writing 0x77 to 0x05 -> outputs/flags cleared asynchronously; RD_ADDR 0x05, RD_DATA -> `dout`=0x77.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcode encodings and default geometry for the SPI command RAM.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int DEFAULT_MEM_DEPTH = 256;
    localparam int DEFAULT_ADDR_SIZE = 8;

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage for spi_ram: one synchronous write port, one registered read port.
// Contents are never reset, so data survives a reset of the control logic.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [0:MEM_DEPTH-1];

    // Read register only loads on a launched read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Command decoder and byte RAM behind the SPI slave (rx_data -> din, dout -> tx_data).
// Define SPI_RAM_AUTOINC_EN to post-increment the addresses after each data access.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    logic                 rx_valid_d;
    logic                 cmd_fire;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_ok;
    logic                 rd_addr_ok;
    logic                 wr_en;
    logic                 rd_en;
    logic                 rd_seen;
    logic [7:0]           rd_data;

    assign cmd_fire = rx_valid && !rx_valid_d;
    assign opcode   = din[9:8];
    assign payload  = din[ADDR_SIZE-1:0];
    assign wr_en    = cmd_fire && (opcode == CMD_WR_DATA) && wr_addr_ok;
    assign rd_en    = cmd_fire && (opcode == CMD_RD_DATA) && rd_addr_ok;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (din[7:0]),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The array read register has no reset; mask it until the first read since reset.
    assign dout = rd_seen ? rd_data : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_addr_ok <= 1'b0;
            rd_addr_ok <= 1'b0;
            tx_valid   <= 1'b0;
            err        <= 1'b0;
            rd_seen    <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
            tx_valid   <= rd_en;
            if (rd_en) begin
                rd_seen <= 1'b1;
            end
            if (cmd_fire) begin
                case (opcode)
                    CMD_WR_ADDR: begin
                        wr_addr    <= payload;
                        wr_addr_ok <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (!wr_addr_ok) begin
                            err <= 1'b1;
                        end
`ifdef SPI_RAM_AUTOINC_EN
                        else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
`endif
                    end
                    CMD_RD_ADDR: begin
                        rd_addr    <= payload;
                        rd_addr_ok <= 1'b1;
                    end
                    default: begin
                        if (!rd_addr_ok) begin
                            err <= 1'b1;
                        end
`ifdef SPI_RAM_AUTOINC_EN
                        else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed self-checking bench for spi_ram; covers the autoinc build when SPI_RAM_AUTOINC_EN is defined.
module tb_spi_ram;
    import spi_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    spi_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present one command with rx_valid high for 'hold' cycles, then drop it.
    task automatic send(input logic [1:0] op, input logic [7:0] p, input int hold);
        @(negedge clk);
        din      = {op, p};
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // RD_DATA with checks on the cycle after the sampling edge and the cycle after that.
    task automatic read_chk(input string tag, input logic [7:0] exp, input logic ok, input logic exp_err);
        @(negedge clk);
        din      = {CMD_RD_DATA, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        check({tag, " tx_valid"}, {31'd0, tx_valid}, {31'd0, ok});
        check({tag, " dout"}, {24'd0, dout}, {24'd0, exp});
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        rx_valid = 1'b0;
        @(negedge clk);
        check({tag, " tx_valid low after"}, {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        #12;
        check("reset dout", {24'd0, dout}, 32'd0);
        check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read back.
        send(CMD_WR_ADDR, 8'h3C, 1);
        send(CMD_WR_DATA, 8'hA5, 1);
        send(CMD_RD_ADDR, 8'h3C, 1);
        read_chk("basic rd 0x3C", 8'hA5, 1'b1, 1'b0);

        // Level held five cycles must give exactly one read pulse.
        send(CMD_RD_ADDR, 8'h3C, 1);
        @(negedge clk);
        din      = {CMD_RD_DATA, 8'h00};
        rx_valid = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pulses += int'(tx_valid);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        pulses += int'(tx_valid);
        check("held rd pulse count", pulses, 32'd1);
        check("held rd dout", {24'd0, dout}, 32'hA5);

`ifdef SPI_RAM_AUTOINC_EN
        send(CMD_WR_ADDR, 8'hFF, 1);
        send(CMD_WR_DATA, 8'h01, 1);
        send(CMD_WR_DATA, 8'h02, 1);
        send(CMD_RD_ADDR, 8'hFF, 1);
        read_chk("autoinc rd 0xFF", 8'h01, 1'b1, 1'b0);
        read_chk("autoinc rd wrap 0x00", 8'h02, 1'b1, 1'b0);
        send(CMD_WR_ADDR, 8'h20, 1);
        send(CMD_WR_DATA, 8'h11, 5);
        send(CMD_WR_DATA, 8'h22, 1);
        send(CMD_RD_ADDR, 8'h20, 1);
        read_chk("held wr rd 0x20", 8'h11, 1'b1, 1'b0);
        read_chk("held wr rd 0x21", 8'h22, 1'b1, 1'b0);
`else
        send(CMD_WR_ADDR, 8'h10, 1);
        send(CMD_WR_DATA, 8'h5A, 1);
        send(CMD_WR_ADDR, 8'h11, 1);
        send(CMD_WR_DATA, 8'hC3, 1);
        send(CMD_RD_ADDR, 8'h10, 1);
        read_chk("reread 0x10 first", 8'h5A, 1'b1, 1'b0);
        read_chk("reread 0x10 second", 8'h5A, 1'b1, 1'b0);
        send(CMD_WR_ADDR, 8'h40, 1);
        send(CMD_WR_DATA, 8'h11, 5);
        send(CMD_RD_ADDR, 8'h40, 1);
        read_chk("held wr rd 0x40", 8'h11, 1'b1, 1'b0);
`endif

        // Write 0x77 to 0x05, read it so dout is non-zero, then reset mid-command.
        send(CMD_WR_ADDR, 8'h05, 1);
        send(CMD_WR_DATA, 8'h77, 1);
        send(CMD_RD_ADDR, 8'h05, 1);
        read_chk("pre-reset rd 0x05", 8'h77, 1'b1, 1'b0);
        send(CMD_WR_ADDR, 8'h05, 1);
        @(negedge clk);
        din      = {CMD_WR_DATA, 8'h99};
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst dout", {24'd0, dout}, 32'd0);
        check("async rst tx_valid", {31'd0, tx_valid}, 32'd0);
        check("async rst err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // RD_DATA without a read address: no pulse, sticky error.
        read_chk("rd before rd_addr", 8'h00, 1'b0, 1'b1);
        send(CMD_RD_ADDR, 8'h05, 1);
        read_chk("post-reset rd 0x05", 8'h77, 1'b1, 1'b1);
        send(CMD_RD_ADDR, 8'h3C, 1);
        read_chk("post-reset rd 0x3C", 8'hA5, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
